// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART TX arbiter: TX FSM state encoding,
// frame tag convention and id-width helper.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_RDY = 2'd1,
    S_STROBE   = 2'd2,
    S_WAIT_ACK = 2'd3
  } tx_state_e;

  // Frame tag carried in the first byte LSB by producers.
  typedef enum logic {
    TAG_DIST  = 1'b0,
    TAG_ANGLE = 1'b1
  } frame_tag_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// rr_pick: combinational round-robin selector.
// Ports: req_valid, ptr in; any (some request), g (chosen index) out.
import uart_tx_arbiter_pkg::*;

module rr_pick #(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [id_width(N_REQ)-1:0] ptr,
  output logic                       any,
  output logic [id_width(N_REQ)-1:0] g
);

  localparam int IDW = id_width(N_REQ);

  int k;

  // Walk from the lowest priority down so the
  // first hit after ptr overwrites the others.
  always_comb begin
    any = 1'b0;
    g   = '0;
    k   = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (req_valid[k]) begin
        any = 1'b1;
        g   = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-level round-robin sharing of one UART TX among N_REQ sources.
// Ports: req_* per source, grant_id/busy/timeout_err status, tx_rdy/data/data_wen to UART.
import uart_tx_arbiter_pkg::*;

module uart_tx_arbiter #(
  parameter int N_REQ       = 3,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic [id_width(N_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err,
  input  logic                       tx_rdy,
  output logic [7:0]                 data,
  output logic                       data_wen
);

  localparam int IDW = id_width(N_REQ);
  localparam int CW  = $clog2(ACK_TIMEOUT) + 1;

  localparam logic [CW-1:0]  CNT_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [IDW-1:0] ID_MAX   = IDW'(N_REQ - 1);

  tx_state_e        state, state_n;
  logic [IDW-1:0]   ptr, ptr_n;
  logic [IDW-1:0]   grant_n;
  logic [IDW-1:0]   nxt_ptr;
  logic             busy_n;
  logic             wen_n;
  logic             terr_n;
  logic             last_q, last_n;
  logic [7:0]       data_n;
  logic [N_REQ-1:0] rdy_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             cnt_sat;
  logic             pick_any;
  logic [IDW-1:0]   pick_g;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req_valid(req_valid),
    .ptr      (ptr),
    .any      (pick_any),
    .g        (pick_g)
  );

  assign nxt_ptr = (grant_id == ID_MAX)
                 ? '0 : grant_id + 1'b1;
  assign cnt_sat = (cnt >= CNT_LAST);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    grant_n = grant_id;
    busy_n  = busy;
    wen_n   = 1'b1;
    terr_n  = 1'b0;
    last_n  = last_q;
    data_n  = data;
    rdy_n   = '0;
    cnt_n   = cnt;
    unique case (state)
      S_IDLE: begin
        if (pick_any) begin
          grant_n = pick_g;
          busy_n  = 1'b1;
          state_n = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        // A silent source keeps the lock;
        // frames never interleave.
        if (tx_rdy && req_valid[grant_id]) begin
          data_n  = req_data[{grant_id, 3'b000} +: 8];
          wen_n   = 1'b0;
          rdy_n[grant_id] = 1'b1;
          last_n  = req_last[grant_id];
          state_n = S_STROBE;
        end
      end
      S_STROBE: begin
        cnt_n   = '0;
        state_n = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        unique case (1'b1)
          !tx_rdy: begin
            if (last_q) begin
              busy_n  = 1'b0;
              ptr_n   = nxt_ptr;
              state_n = S_IDLE;
            end else begin
              state_n = S_WAIT_RDY;
            end
          end
          tx_rdy && cnt_sat: begin
            terr_n  = 1'b1;
            busy_n  = 1'b0;
            ptr_n   = nxt_ptr;
            state_n = S_IDLE;
          end
          tx_rdy && !cnt_sat: begin
            cnt_n = cnt + 1'b1;
          end
          default: begin
            state_n = S_IDLE;
          end
        endcase
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      data_wen    <= 1'b1;
      timeout_err <= 1'b0;
      last_q      <= 1'b0;
      data        <= 8'h00;
      req_ready   <= '0;
      cnt         <= '0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      grant_id    <= grant_n;
      busy        <= busy_n;
      data_wen    <= wen_n;
      timeout_err <= terr_n;
      last_q      <= last_n;
      data        <= data_n;
      req_ready   <= rdy_n;
      cnt         <= cnt_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (N_REQ=3, ACK_TIMEOUT=16).
// Directed table of arbitration rounds plus hand-written corner sequences.
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   req_valid;
  logic [23:0]  req_data;
  logic [2:0]   req_last;
  logic [2:0]   req_ready;
  logic [1:0]   grant_id;
  logic         busy;
  logic         timeout_err;
  logic         tx_rdy;
  logic [7:0]   data;
  logic         data_wen;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ(N),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .grant_id(grant_id),
    .busy(busy),
    .timeout_err(timeout_err),
    .tx_rdy(tx_rdy),
    .data(data),
    .data_wen(data_wen)
  );

  int total = 0;
  int bad = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] q2[$];
  logic [9:0] lg[$];

  logic model_en;
  logic drop_pending;
  logic prev_wen;
  int   hold;

  typedef struct {
    logic [2:0]      mask;
    int              n;
    logic [2:0][1:0] ord;
  } vec_t;

  vec_t vec [10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] lg_at(input int i);
    if (i < lg.size()) return lg[i];
    return 10'h3ff;
  endfunction

  task automatic push_q(input int i, input logic [8:0] v);
    case (i)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic present();
    req_valid[0] = q0.size() != 0;
    req_valid[1] = q1.size() != 0;
    req_valid[2] = q2.size() != 0;
    req_data[7:0]   = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
    req_data[15:8]  = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
    req_data[23:16] = (q2.size() != 0) ? q2[0][7:0] : 8'h00;
    req_last[0] = (q0.size() != 0) ? q0[0][8] : 1'b0;
    req_last[1] = (q1.size() != 0) ? q1[0][8] : 1'b0;
    req_last[2] = (q2.size() != 0) ? q2[0][8] : 1'b0;
  endtask

  // One clock: sample outputs 1ns after the edge, run the
  // requester and UART models, then drive new inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!data_wen) begin
      lg.push_back({grant_id, data});
      chk("rdy_onehot", req_ready, 32'(3'b001 << grant_id));
      chk("wen_1cyc", prev_wen, 1);
    end else begin
      chk("rdy_idle", req_ready, 0);
    end
    prev_wen = data_wen;
    if (req_ready[0] && q0.size() != 0) void'(q0.pop_front());
    if (req_ready[1] && q1.size() != 0) void'(q1.pop_front());
    if (req_ready[2] && q2.size() != 0) void'(q2.pop_front());
    if (model_en) begin
      if (hold > 0) begin
        hold--;
        if (hold == 0) tx_rdy = 1'b1;
      end
      if (drop_pending) begin
        tx_rdy = 1'b0;
        hold = 2;
        drop_pending = 1'b0;
      end
      if (!data_wen) drop_pending = 1'b1;
    end
    present();
  endtask

  task automatic run_idle(input string nm, input int max);
    logic done;
    done = 1'b0;
    for (int k = 0; k < max; k++) begin
      tick();
      if (!busy && data_wen && tx_rdy && q0.size() == 0 &&
          q1.size() == 0 && q2.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk(nm, done, 1);
  endtask

  task automatic do_reset();
    q0.delete();
    q1.delete();
    q2.delete();
    lg.delete();
    model_en = 1'b1;
    drop_pending = 1'b0;
    hold = 0;
    tx_rdy = 1'b1;
    prev_wen = 1'b1;
    present();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1);
  end

  initial begin
    logic [9:0] e;
    int k;
    int lows;

    vec[0] = '{3'b111, 3, {2'd2, 2'd1, 2'd0}};
    vec[1] = '{3'b111, 3, {2'd2, 2'd1, 2'd0}};
    vec[2] = '{3'b110, 2, {2'd0, 2'd2, 2'd1}};
    vec[3] = '{3'b101, 2, {2'd0, 2'd2, 2'd0}};
    vec[4] = '{3'b010, 1, {2'd0, 2'd0, 2'd1}};
    vec[5] = '{3'b011, 2, {2'd0, 2'd1, 2'd0}};
    vec[6] = '{3'b111, 3, {2'd1, 2'd0, 2'd2}};
    vec[7] = '{3'b100, 1, {2'd0, 2'd0, 2'd2}};
    vec[8] = '{3'b001, 1, {2'd0, 2'd0, 2'd0}};
    vec[9] = '{3'b101, 2, {2'd0, 2'd0, 2'd2}};

    model_en = 1'b1;
    drop_pending = 1'b0;
    hold = 0;
    tx_rdy = 1'b1;
    prev_wen = 1'b1;
    present();
    tick();
    tick();
    chk("rst_wen", data_wen, 1);
    chk("rst_data", data, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);
    rst_n = 1'b1;
    tick();

    // 2-byte frame on req 0 with latency check
    lg.delete();
    q0.push_back({1'b0, 8'h42});
    q0.push_back({1'b1, 8'h81});
    tick();
    tick();
    chk("B_grant_busy", busy, 1);
    chk("B_grant_wen", data_wen, 1);
    tick();
    chk("B_strobe_wen", data_wen, 0);
    chk("B_strobe_data", data, 8'h42);
    run_idle("B_done", 100);
    chk("B_count", lg.size(), 2);
    chk("B_byte0", lg_at(0), {2'd0, 8'h42});
    chk("B_byte1", lg_at(1), {2'd0, 8'h81});
    chk("B_busy_end", busy, 0);

    // Arbitration table, starting from ptr=0
    do_reset();
    for (int r = 0; r < 10; r++) begin
      lg.delete();
      for (int i = 0; i < 3; i++)
        if (vec[r].mask[i])
          push_q(i, {1'b1, 8'(8'h20 + 4 * r + i)});
      run_idle($sformatf("tbl%0d_done", r), 200);
      chk($sformatf("tbl%0d_cnt", r), lg.size(), vec[r].n);
      for (int j = 0; j < vec[r].n; j++) begin
        e = lg_at(j);
        chk($sformatf("tbl%0d_id%0d", r, j),
            e[9:8], vec[r].ord[j]);
        chk($sformatf("tbl%0d_data%0d", r, j), e[7:0],
            8'(8'h20 + 4 * r + int'(vec[r].ord[j])));
      end
    end

    // req 1 frame locked while req 0 arrives
    lg.delete();
    q1.push_back({1'b0, 8'h51});
    q1.push_back({1'b1, 8'h52});
    for (k = 0; k < 100; k++) begin
      tick();
      if (lg.size() >= 1) break;
    end
    chk("D_first_byte", lg.size(), 1);
    q0.push_back({1'b1, 8'h53});
    run_idle("D_done", 200);
    chk("D_count", lg.size(), 3);
    chk("D_byte0", lg_at(0), {2'd1, 8'h51});
    chk("D_byte1", lg_at(1), {2'd1, 8'h52});
    chk("D_byte2", lg_at(2), {2'd0, 8'h53});

    // tx_rdy low at grant for 50 cycles
    model_en = 1'b0;
    tx_rdy = 1'b0;
    lg.delete();
    q2.push_back({1'b1, 8'h61});
    for (k = 0; k < 20; k++) begin
      tick();
      if (busy) break;
    end
    chk("E_busy", busy, 1);
    chk("E_grant", grant_id, 2);
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!data_wen) lows++;
    end
    chk("E_no_wen", lows, 0);
    tx_rdy = 1'b1;
    model_en = 1'b1;
    drop_pending = 1'b0;
    hold = 0;
    tick();
    chk("E_wen", data_wen, 0);
    chk("E_data", data, 8'h61);
    run_idle("E_done", 100);

    // No ack after strobe: timeout and move on
    model_en = 1'b0;
    tx_rdy = 1'b1;
    lg.delete();
    q0.push_back({1'b0, 8'hA1});
    q0.push_back({1'b1, 8'hA2});
    q1.push_back({1'b1, 8'hB1});
    for (k = 0; k < 20; k++) begin
      tick();
      if (!data_wen) break;
    end
    chk("F_strobe", data_wen, 0);
    chk("F_data", data, 8'hA1);
    chk("F_grant", grant_id, 0);
    k = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      k++;
      if (timeout_err) break;
    end
    chk("F_to_lat", k, TO + 1);
    chk("F_terr", timeout_err, 1);
    chk("F_busy_off", busy, 0);
    q0.delete();
    tick();
    chk("F_terr_pulse", timeout_err, 0);
    chk("F_next_grant", grant_id, 1);
    chk("F_next_busy", busy, 1);
    model_en = 1'b1;
    run_idle("F_done", 100);
    chk("F_count", lg.size(), 2);
    chk("F_last", lg_at(1), {2'd1, 8'hB1});

    // Reset while strobing
    lg.delete();
    q2.push_back({1'b1, 8'h71});
    for (k = 0; k < 20; k++) begin
      tick();
      if (!data_wen) break;
    end
    chk("G_strobe", data_wen, 0);
    rst_n = 1'b0;
    #1;
    chk("G_rst_wen", data_wen, 1);
    chk("G_rst_ready", req_ready, 0);
    chk("G_rst_busy", busy, 0);
    chk("G_rst_grant", grant_id, 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    lg.delete();
    q1.push_back({1'b1, 8'h81});
    q0.push_back({1'b1, 8'h82});
    run_idle("G_done", 100);
    chk("G_count", lg.size(), 2);
    chk("G_first", lg_at(0), {2'd0, 8'h82});
    chk("G_second", lg_at(1), {2'd1, 8'h81});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
